bios_loader: RTL and testbench
==============================

BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 The block SHALL have parameter WORDS, default 4096, giving the number of 16-bit BIOS words in a complete image.
REQ-002 The block SHALL have parameter BURST, default 32, giving the words per bios_wr burst; it SHALL be a power of two and at most 64.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports:
- clk_sys  in  1  sole clock
- reset_n  in  1  async active-low reset
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  byte strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  stall request to HPS
- bios_addr  out  13  word address to system
- bios_din  out  16  word data to system
- bios_wr  out  1  burst active
- bios_req  in  1  system consumes the current word
- bios_loaded  out  1  image complete and valid
- load_err  out  1  image size mismatch
- checksum  out  16  image checksum

Function
REQ-005 Bytes SHALL pack little-endian: even ioctl_addr supplies the low byte, odd ioctl_addr the high byte; a word is committed to the buffer on the odd-byte strobe.
REQ-006 Buffering SHALL be a 2*BURST-word ping-pong buffer; a half becomes ready when BURST words are committed to it.
REQ-007 ioctl_wait SHALL be 1 from the cycle after both halves become ready until one half drains, then 0; bytes strobed while ioctl_wait=1 SHALL still be accepted.
REQ-008 FSM states SHALL be IDLE, FILL, BURST, FLUSH, DONE.
REQ-009 IDLE->FILL SHALL occur on the ioctl_download rising edge; this edge SHALL clear bios_addr, the pointers, bios_loaded, load_err and checksum.
REQ-010 FILL->BURST SHALL occur when a half is ready; bios_wr SHALL be 1 throughout BURST.
REQ-011 While bios_wr=1, bios_din/bios_addr SHALL present the current word; on each edge with bios_req=1, bios_addr SHALL increment by 1 and the next buffered word SHALL appear the following cycle.
REQ-012 After BURST consumptions, bios_wr SHALL drop the next cycle; the FSM SHALL enter FILL, or BURST again if the other half is ready.
REQ-013 On the ioctl_download falling edge, a pending odd low byte SHALL commit with high byte 0x00, and the FSM SHALL enter FLUSH.
REQ-014 FLUSH SHALL burst only the valid words of any partial half, then enter DONE.
REQ-015 In DONE: bios_loaded=1 iff the total word count equals WORDS, otherwise load_err=1; both SHALL hold until the next download rising edge.
REQ-016 Words beyond WORDS SHALL be discarded, not written, and SHALL set load_err.
REQ-017 A download rising edge in any state SHALL abort the current operation and restart per REQ-009.

Reset
REQ-018 On reset_n=0 the FSM SHALL enter IDLE and all outputs SHALL be 0, independent of clk_sys.
REQ-019 Reset mid-burst SHALL drop bios_wr immediately; buffer contents need not be cleared.

Configuration
REQ-020 With BIOS_LOADER_CHECKSUM_EN defined, checksum SHALL be the mod-2^16 sum of all words written to the system, final in DONE.
REQ-021 Without BIOS_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder logic SHALL be generated.

Structure
REQ-022 Package bios_loader_pkg SHALL hold the FSM state enum and the default WORDS/BURST constants.
REQ-023 Sub-module bios_loader_buf SHALL implement the 2*BURST x 16 buffer: one write port, one registered read port.

Verification
REQ-024 Full image: 8192 bytes, byte n = n[7:0] -> 4096 words written, word k = {(2k+1)[7:0], (2k)[7:0]}, bios_loaded=1, load_err=0.
REQ-025 Backpressure: bios_req held 0 for 200 cycles mid-download -> ioctl_wait=1 after 64 words, no word lost or duplicated, final bios_addr=4096.
REQ-026 Short image: 101 bytes -> last word = 0x00 in the high byte plus byte 100 in the low byte, 51 words written, load_err=1, bios_loaded=0.
REQ-027 Overflow: 8200 bytes -> exactly 4096 words written, load_err=1.
REQ-028 Reset with reset_n=0 at word 1000 mid-burst -> bios_wr=0 in the same cycle; a new full download then completes with bios_loaded=1.
REQ-029 Checksum: with BIOS_LOADER_CHECKSUM_EN defined and all bytes 0x01 -> checksum = 4096*0x0101 mod 2^16 = 0x1000; without the macro -> checksum = 0.

Source files
------------

// File: rtl/bios_loader_pkg.sv
// Shared FSM state encoding and default image geometry for the BIOS loader.
package bios_loader_pkg;
   localparam int DEF_WORDS = 4096;
   localparam int DEF_BURST = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_BURST,
      ST_FLUSH,
      ST_DONE
   } state_t;
endpackage

// File: rtl/bios_loader_buf.sv
// Ping-pong word buffer for the BIOS loader: one write port and one registered read port.
module bios_loader_buf #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk_sys,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data
);
   logic [15:0] mem [0:DEPTH-1];

   always_ff @(posedge clk_sys) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/bios_loader.sv
// Packs HPS download bytes into 16-bit words and replays them to the system in bursts.
// Optional image checksum is built only when BIOS_LOADER_CHECKSUM_EN is defined.
module bios_loader
   import bios_loader_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   parameter int BURST = DEF_BURST
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [12:0] bios_addr,
   output logic [15:0] bios_din,
   output logic        bios_wr,
   input  logic        bios_req,
   output logic        bios_loaded,
   output logic        load_err,
   output logic [15:0] checksum
);
   localparam int PTR_W = $clog2(2 * BURST);
   localparam int CNT_W = $clog2(WORDS + 1);
   localparam logic [PTR_W-1:0] LOW_MASK = PTR_W'(BURST - 1);
   localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'(WORDS);

   state_t           state_q, state_d;
   logic             dl_q;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]       ready_q, ready_d, ready_set, ready_clr;
   logic [7:0]       low_q, low_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, flush_q, flush_d;
   logic [12:0]      addr_q, addr_d;
   logic             wait_q, wait_d, loaded_q, loaded_d, err_q, err_d;
   logic             rise, fall, accept, consume, rd_last, do_commit, wr_en;
   logic [15:0]      commit_word, wr_data, rd_data;
   logic             unused_addr;

   assign unused_addr = ^ioctl_addr[24:1];
   assign rise    = ioctl_download & ~dl_q;
   assign fall    = ~ioctl_download & dl_q;
   assign accept  = ((state_q == ST_FILL) || (state_q == ST_BURST)) && !flush_q;
   assign bios_wr = (state_q == ST_BURST);
   assign consume = bios_wr & bios_req;
   // During flush the last half may be partial, so the burst also stops at the write pointer.
   assign rd_last = consume &&
                    (((rd_ptr_q & LOW_MASK) == LOW_MASK) ||
                     (flush_q && ((rd_ptr_q + PTR_W'(1)) == wr_ptr_q)));

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ready_set   = '0;
      ready_clr   = '0;
      low_d       = low_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      flush_d     = flush_q;
      addr_d      = addr_q;
      loaded_d    = loaded_q;
      err_d       = err_q;
      do_commit   = 1'b0;
      commit_word = '0;
      wr_en       = 1'b0;
      wr_data     = '0;

      if (accept && ioctl_download && ioctl_wr) begin
         if (ioctl_addr[0]) begin
            do_commit   = 1'b1;
            commit_word = {ioctl_dout, low_q};
            pend_d      = 1'b0;
         end else begin
            low_d  = ioctl_dout;
            pend_d = 1'b1;
         end
      end else if (accept && fall && pend_q) begin
         do_commit   = 1'b1;
         commit_word = {8'h00, low_q};
         pend_d      = 1'b0;
      end

      if (do_commit) begin
         if (cnt_q == WORDS_C) begin
            ovf_d = 1'b1;
         end else begin
            wr_en    = 1'b1;
            wr_data  = commit_word;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d    = cnt_q + CNT_W'(1);
            if ((wr_ptr_q & LOW_MASK) == LOW_MASK) ready_set[wr_ptr_q[PTR_W-1]] = 1'b1;
         end
      end

      if (consume) begin
         addr_d   = addr_q + 13'd1;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (rd_last) ready_clr[rd_ptr_q[PTR_W-1]] = 1'b1;
      end

      case (state_q)
         ST_FILL: begin
            if (fall) begin
               flush_d = 1'b1;
               state_d = ST_FLUSH;
            end else if (ready_q[rd_ptr_q[PTR_W-1]]) begin
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (fall) flush_d = 1'b1;
            if (rd_last) state_d = (flush_q || fall) ? ST_FLUSH : ST_FILL;
         end
         ST_FLUSH: begin
            if (ready_q[rd_ptr_q[PTR_W-1]] || (rd_ptr_q != wr_ptr_q)) begin
               state_d = ST_BURST;
            end else begin
               state_d  = ST_DONE;
               loaded_d = !ovf_q && (cnt_q == WORDS_C);
               err_d    = ovf_q || (cnt_q != WORDS_C);
            end
         end
         default: ;
      endcase

      if (rise) begin
         state_d   = ST_FILL;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         ready_set = '0;
         ready_clr = 2'b11;
         pend_d    = 1'b0;
         cnt_d     = '0;
         ovf_d     = 1'b0;
         flush_d   = 1'b0;
         addr_d    = '0;
         loaded_d  = 1'b0;
         err_d     = 1'b0;
         wr_en     = 1'b0;
      end

      ready_d = (ready_q & ~ready_clr) | ready_set;
      wait_d  = &ready_d;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         dl_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ready_q  <= '0;
         low_q    <= '0;
         pend_q   <= 1'b0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         flush_q  <= 1'b0;
         addr_q   <= '0;
         wait_q   <= 1'b0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dl_q     <= ioctl_download;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ready_q  <= ready_d;
         low_q    <= low_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         flush_q  <= flush_d;
         addr_q   <= addr_d;
         wait_q   <= wait_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
      end
   end

   // Read address runs one step ahead so the registered read shows rd_ptr_q's word.
   bios_loader_buf #(
      .DEPTH (2 * BURST),
      .AW    (PTR_W)
   ) u_buf (
      .clk_sys (clk_sys),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_d),
      .rd_data (rd_data)
   );

   assign ioctl_wait  = wait_q;
   assign bios_addr   = addr_q;
   assign bios_din    = bios_wr ? rd_data : 16'h0000;
   assign bios_loaded = loaded_q;
   assign load_err    = err_q;

`ifdef BIOS_LOADER_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (rise)         sum_d = '0;
      else if (consume) sum_d = sum_q + bios_din;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) sum_q <= '0;
      else          sum_q <= sum_d;
   end

   assign checksum = sum_q;
`else
   assign checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_bios_loader.sv
// Bench for bios_loader: table of image downloads plus random images, checked against a byte-level model.
// Checksum expectations follow BIOS_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_bios_loader;
   localparam int WORDS = 4096;
   localparam int BURST = 32;
`ifdef BIOS_LOADER_CHECKSUM_EN
   localparam logic [15:0] CK_ONES = 16'h1000;
`else
   localparam logic [15:0] CK_ONES = 16'h0000;
`endif

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        ioctl_wait;
   logic [12:0] bios_addr;
   logic [15:0] bios_din;
   logic        bios_wr;
   logic        bios_req = 1'b0;
   logic        bios_loaded;
   logic        load_err;
   logic [15:0] checksum;

   bios_loader #(.WORDS(WORDS), .BURST(BURST)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .bios_addr      (bios_addr),
      .bios_din       (bios_din),
      .bios_wr        (bios_wr),
      .bios_req       (bios_req),
      .bios_loaded    (bios_loaded),
      .load_err       (load_err),
      .checksum       (checksum)
   );

   initial forever #5 clk_sys = ~clk_sys;

   typedef struct {
      int          nbytes;
      int          pat;        // 0: n[7:0], 1: all 0x01, 2: random
      int          stall_at;   // consumed-word count that starts a 200-cycle bios_req=0 window, -1 none
      bit          gaps;
      bit          exp_loaded;
      bit          exp_err;
      int          exp_words;
      bit          chk_last;
      logic [15:0] exp_last;
      bit          chk_ck;
      logic [15:0] exp_ck;
   } vec_t;

   int total = 0;
   int bad = 0;

   logic [7:0]  bytes [0:8299];
   logic [15:0] exp_q [$];
   logic [12:0] rx_addr [$];
   logic [15:0] rx_data [$];
   int drv_idx = 0, drv_n = 0, sent = 0, consumed = 0;
   int stall_at = -1, stall_left = 0, wait_backlog = 0;
   bit drv_on = 0, drv_gaps = 0, in_stall = 0, wait_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One negedge step of both the HPS byte driver and the system-side consumer.
   task automatic bus_cycle();
      @(negedge clk_sys);
      if (in_stall && ioctl_wait && !wait_seen) begin
         wait_seen    = 1;
         wait_backlog = sent - consumed;
      end
      ioctl_wr = 1'b0;
      if (drv_on && !ioctl_wait && drv_idx < drv_n && (!drv_gaps || $urandom_range(0, 3) != 0)) begin
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(drv_idx);
         ioctl_dout = bytes[drv_idx];
         if (drv_idx % 2 == 1) sent++;
         drv_idx++;
      end
      if (stall_at >= 0 && consumed == stall_at) begin
         stall_left = 200;
         stall_at   = -1;
      end
      if (stall_left > 0) begin
         bios_req = 1'b0;
         stall_left--;
         in_stall = 1;
      end else begin
         bios_req = ($urandom_range(0, 3) != 0);
         in_stall = 0;
      end
      if (bios_wr && bios_req && reset_n) begin
         rx_addr.push_back(bios_addr);
         rx_data.push_back(bios_din);
         consumed++;
      end
   endtask

   task automatic fill_bytes(input int n, input int pat);
      for (int i = 0; i < n; i++) begin
         case (pat)
            0:       bytes[i] = 8'(i);
            1:       bytes[i] = 8'h01;
            default: bytes[i] = 8'($urandom);
         endcase
      end
   endtask

   task automatic start_download(input vec_t v);
      fill_bytes(v.nbytes, v.pat);
      rx_addr.delete();
      rx_data.delete();
      drv_idx = 0; drv_n = v.nbytes; sent = 0; consumed = 0;
      stall_at = v.stall_at; stall_left = 0; wait_seen = 0; wait_backlog = 0;
      drv_gaps = v.gaps;
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      drv_on = 1;
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc;
      int          mis;
      logic [15:0] sum;
      logic [15:0] last;
      logic [15:0] exp_sum;
      start_download(v);
      cyc = 0;
      while (drv_idx < v.nbytes && cyc < 4 * v.nbytes + 2000) begin
         bus_cycle();
         cyc++;
      end
      chk("drive_timeout", 32'(drv_idx), 32'(v.nbytes));
      bus_cycle();
      drv_on = 0;
      ioctl_download = 1'b0;
      cyc = 0;
      while (!bios_loaded && !load_err && cyc < 5000) begin
         bus_cycle();
         cyc++;
      end
      chk("done_timeout", 32'(bios_loaded | load_err), 32'd1);

      // Model: little-endian pairs, odd tail padded with 0x00, truncated to WORDS.
      exp_q.delete();
      sum = '0;
      for (int k = 0; 2 * k < v.nbytes && k < WORDS; k++) begin
         logic [7:0] hi;
         hi = (2 * k + 1 < v.nbytes) ? bytes[2 * k + 1] : 8'h00;
         exp_q.push_back({hi, bytes[2 * k]});
         sum = sum + {hi, bytes[2 * k]};
      end
`ifdef BIOS_LOADER_CHECKSUM_EN
      exp_sum = sum;
`else
      exp_sum = 16'h0000;
`endif
      mis = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (mis == -1 && (i >= rx_data.size() || rx_data[i] !== exp_q[i] || rx_addr[i] !== 13'(i)))
            mis = i;
      end
      last = (rx_data.size() > 0) ? rx_data[rx_data.size() - 1] : 16'hxxxx;

      chk("word_count", 32'(rx_data.size()), 32'(v.exp_words));
      chk("stream_first_bad_idx", 32'(mis), 32'hFFFF_FFFF);
      chk("final_addr", 32'(bios_addr), 32'(v.exp_words));
      chk("loaded", 32'(bios_loaded), 32'(v.exp_loaded));
      chk("load_err", 32'(load_err), 32'(v.exp_err));
      chk("checksum_model", 32'(checksum), 32'(exp_sum));
      if (v.chk_last) chk("last_word", 32'(last), 32'(v.exp_last));
      if (v.chk_ck)   chk("checksum_hand", 32'(checksum), 32'(v.exp_ck));
      if (v.stall_at >= 0) begin
         chk("wait_seen_in_stall", 32'(wait_seen), 32'd1);
         chk("backlog_at_wait", 32'(wait_backlog), 32'd64);
      end
      $display("download n=%0d pat=%0d words=%0d addr=%0d loaded=%0b err=%0b ck=%04h",
               v.nbytes, v.pat, rx_data.size(), bios_addr, bios_loaded, load_err, checksum);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bios_wr"}, 32'(bios_wr), 32'd0);
      chk({tag, "_outputs"}, {ioctl_wait, bios_loaded, load_err, bios_addr, 16'h0000},
          {3'b000, 13'h0, 16'h0000});
      chk({tag, "_din_ck"}, {bios_din, checksum}, 32'h0);
   endtask

   vec_t vecs [8];

   initial begin
      vec_t r;
      int   cyc;
      vecs[0] = '{8192, 0, -1,   0, 1, 0, 4096, 1, 16'hFFFE, 0, 16'h0};
      vecs[1] = '{101,  0, -1,   0, 0, 1, 51,   1, 16'h0064, 0, 16'h0};
      vecs[2] = '{8200, 0, -1,   0, 0, 1, 4096, 1, 16'hFFFE, 0, 16'h0};
      vecs[3] = '{8192, 1, -1,   0, 1, 0, 4096, 1, 16'h0101, 1, CK_ONES};
      vecs[4] = '{8192, 0, 1024, 0, 1, 0, 4096, 1, 16'hFFFE, 0, 16'h0};
      vecs[5] = '{64,   0, -1,   1, 0, 1, 32,   1, 16'h3F3E, 0, 16'h0};
      vecs[6] = '{128,  0, -1,   1, 0, 1, 64,   1, 16'h7F7E, 0, 16'h0};
      vecs[7] = '{3,    0, -1,   1, 0, 1, 2,    1, 16'h0002, 0, 16'h0};

      #2;
      chk_all_zero("reset");
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      chk_all_zero("post_reset");

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      for (int i = 0; i < 4; i++) begin
         r.nbytes     = $urandom_range(1, 700);
         r.pat        = 2;
         r.stall_at   = -1;
         r.gaps       = 1;
         r.exp_words  = (r.nbytes + 1) / 2;
         r.exp_loaded = 0;
         r.exp_err    = 1;
         r.chk_last   = 0;
         r.exp_last   = '0;
         r.chk_ck     = 0;
         r.exp_ck     = '0;
         run_vec(r);
      end

      // Reset in the middle of a burst, then a clean full image.
      r = vecs[0];
      start_download(r);
      cyc = 0;
      while (!(consumed >= 1000 && bios_wr) && cyc < 10000) begin
         bus_cycle();
         cyc++;
      end
      chk("reach_word_1000", 32'(bios_wr), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk_all_zero("midburst_reset");
      $display("reset asserted at consumed=%0d", consumed);
      drv_on = 0;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      bios_req = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      run_vec(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
